// File: rtl/frame_buf_arbiter_if.sv
// Bus bundle between the frame buffer arbiter and its three neighbours:
// the VIP write stream, the display FIFO push side and the single-port
// frame buffer RAM. Clock and reset are kept outside the bundle.
//
// Signals:
//   frame_start    vsync pulse, restarts the display read pointer
//   rd_fifo_level  display FIFO word count (7-bit unsigned)
//   rd_fifo_wr     display FIFO push strobe
//   rd_fifo_wdata  display FIFO push data
//   wr_valid       processed pixel valid
//   wr_ready       processed pixel accepted when wr_valid && wr_ready
//   wr_data        processed pixel
//   wr_sof         marks an accepted beat as the first pixel of a frame
//   mem_en         RAM access enable
//   mem_we         RAM write enable (read when 0)
//   mem_addr       RAM address
//   mem_wdata      RAM write data
//   mem_rdata      RAM read data, valid one cycle after a read access
//   rd_frame_done  pulse alongside the push of a frame's last pixel
//
// Modports:
//   master  the arbiter
//   slave   the surrounding system (VIP, FIFO, RAM)
interface frame_buf_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 16
);
  logic              frame_start;
  logic [6:0]        rd_fifo_level;
  logic              rd_fifo_wr;
  logic [DATA_W-1:0] rd_fifo_wdata;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              wr_sof;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              rd_frame_done;

  modport master (
    input  frame_start, rd_fifo_level, wr_valid, wr_data, wr_sof, mem_rdata,
    output rd_fifo_wr, rd_fifo_wdata, wr_ready, mem_en, mem_we, mem_addr,
           mem_wdata, rd_frame_done
  );

  modport slave (
    output frame_start, rd_fifo_level, wr_valid, wr_data, wr_sof, mem_rdata,
    input  rd_fifo_wr, rd_fifo_wdata, wr_ready, mem_en, mem_we, mem_addr,
           mem_wdata, rd_frame_done
  );
endinterface

// File: rtl/frame_buf_arbiter.sv
// Frame buffer arbiter: shares one single-port RAM between the display read
// path (fills the pixel FIFO) and the VIP write path (stores processed
// pixels). Work is done in fixed-length bursts separated by at least one
// IDLE cycle, in which the next grant is chosen:
//   1. urgent read  (FIFO below LOW_WM and a whole burst fits)
//   2. write, if the previous grant was a read and a pixel is waiting
//   3. read, if a whole burst fits
//   4. write, if a pixel is waiting
// A frame_start only marks the read pointer for restart; the restart is
// applied in the next IDLE cycle so a running burst is never cut short.
//
// Ports:
//   pixel_clk  pixel clock, the only clock
//   sys_rst    synchronous active-high reset
//   bus        frame_buf_arbiter_if.master (VIP stream, FIFO push, RAM port)
module frame_buf_arbiter #(
  parameter int H_DISP     = 640,
  parameter int V_DISP     = 480,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 16,
  parameter int BURST      = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int LOW_WM     = 16
) (
  input  logic                 pixel_clk,
  input  logic                 sys_rst,
  frame_buf_arbiter_if.master  bus
);

  localparam int FRAME = H_DISP * V_DISP;
  localparam int CNT_W = $clog2(BURST + 1);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME - 1);
  localparam logic [ADDR_W:0]   FRAME_X   = (ADDR_W + 1)'(FRAME);
  localparam logic [ADDR_W:0]   BURST_X   = (ADDR_W + 1)'(BURST);
  localparam logic [CNT_W-1:0]  BURST_C   = CNT_W'(BURST);
  // Highest FIFO level at which a full burst plus the push still in flight fits.
  localparam logic [7:0]        ROOM_MAX  = 8'(FIFO_DEPTH - BURST - 1);
  localparam logic [6:0]        LOW_LVL   = 7'(LOW_WM);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [CNT_W-1:0]  beat_cnt;
  logic [CNT_W-1:0]  rd_len;
  logic              restart_pend;
  logic              last_grant;   // 0 = read, 1 = write
  logic              vld_p1;
  logic              done_p1;

  logic              room;
  logic              urgent;
  logic [ADDR_W-1:0] rd_base;
  logic              rd_acc;
  logic              wr_ready_c;
  logic              wr_fire;
  logic [ADDR_W-1:0] wr_mem_addr;

  // A read burst never runs past the end of the frame.
  function automatic logic [CNT_W-1:0] burst_len(input logic [ADDR_W-1:0] base);
    logic [ADDR_W:0] rem;
    rem = FRAME_X - {1'b0, base};
    if (rem < BURST_X) burst_len = CNT_W'(rem);
    else               burst_len = BURST_C;
  endfunction

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    if (a == LAST_ADDR) addr_inc = '0;
    else                addr_inc = a + 1'b1;
  endfunction

  // A pending restart is applied in the same IDLE cycle that arbitrates, so
  // the burst length must already be computed from address 0.
  assign rd_base = restart_pend ? '0 : rd_addr;
  assign room    = ({1'b0, bus.rd_fifo_level} <= ROOM_MAX);
  assign urgent  = (bus.rd_fifo_level < LOW_LVL) && room;

  assign rd_acc      = (state == RD_BURST);
  assign wr_ready_c  = (state == WR_BURST) && (beat_cnt < BURST_C);
  assign wr_fire     = wr_ready_c && bus.wr_valid;
  assign wr_mem_addr = bus.wr_sof ? '0 : wr_addr;

  // Read accesses are a decode of registered state; write beats must reach
  // the RAM in the cycle they are accepted, so they bypass any register.
  assign bus.wr_ready      = wr_ready_c;
  assign bus.mem_en        = rd_acc | wr_fire;
  assign bus.mem_we        = wr_fire;
  assign bus.mem_addr      = rd_acc ? rd_addr : (wr_fire ? wr_mem_addr : '0);
  assign bus.mem_wdata     = wr_fire ? bus.wr_data : '0;

  // ---- stage p1: RAM read data returns, pushed straight into the FIFO ----
  assign bus.rd_fifo_wr    = vld_p1;
  assign bus.rd_fifo_wdata = vld_p1 ? bus.mem_rdata : '0;
  assign bus.rd_frame_done = done_p1;

  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      state        <= IDLE;
      rd_addr      <= '0;
      wr_addr      <= '0;
      beat_cnt     <= '0;
      rd_len       <= '0;
      restart_pend <= 1'b0;
      last_grant   <= 1'b0;
      vld_p1       <= 1'b0;
      done_p1      <= 1'b0;
    end else begin
      vld_p1  <= rd_acc;
      done_p1 <= rd_acc && (rd_addr == LAST_ADDR);

      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (restart_pend) begin
            rd_addr      <= '0;
            restart_pend <= 1'b0;
          end
          if (urgent) begin
            state      <= RD_BURST;
            rd_len     <= burst_len(rd_base);
            last_grant <= 1'b0;
          end else if (!last_grant && bus.wr_valid) begin
            state      <= WR_BURST;
            last_grant <= 1'b1;
          end else if (room) begin
            state      <= RD_BURST;
            rd_len     <= burst_len(rd_base);
            last_grant <= 1'b0;
          end else if (bus.wr_valid) begin
            state      <= WR_BURST;
            last_grant <= 1'b1;
          end
        end

        RD_BURST: begin
          rd_addr  <= addr_inc(rd_addr);
          beat_cnt <= beat_cnt + 1'b1;
          if (beat_cnt + 1'b1 == rd_len) state <= IDLE;
        end

        WR_BURST: begin
          if (!bus.wr_valid) begin
            state <= IDLE;
          end else if (wr_fire) begin
            // An SOF beat lands at 0, so the next beat follows at 1.
            wr_addr  <= addr_inc(wr_mem_addr);
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt + 1'b1 == BURST_C) state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

      // Placed last so a frame_start in the clearing IDLE cycle wins.
      if (bus.frame_start) restart_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_buf_arbiter.sv
// Testbench for frame_buf_arbiter: small frame (20x9) so frame wrap and a
// short final burst occur quickly. A RAM model sits on the memory port; a
// burst-level reference model predicts every RAM access and FIFO push into
// queues, and a monitor pops and compares whenever the DUT acts.
module tb_frame_buf_arbiter;
  localparam int H_DISP     = 20;
  localparam int V_DISP     = 9;
  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 16;
  localparam int BURST      = 16;
  localparam int FIFO_DEPTH = 64;
  localparam int LOW_WM     = 16;
  localparam int FRAME      = H_DISP * V_DISP;

  typedef struct {
    int cyc;
    bit we;
    int addr;
    int data;
  } acc_t;

  typedef struct {
    int cyc;
    int data;
    bit done;
  } push_t;

  logic pixel_clk = 1'b0;
  logic sys_rst   = 1'b1;

  frame_buf_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  frame_buf_arbiter #(
    .H_DISP(H_DISP), .V_DISP(V_DISP), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .BURST(BURST), .FIFO_DEPTH(FIFO_DEPTH), .LOW_WM(LOW_WM)
  ) dut (
    .pixel_clk (pixel_clk),
    .sys_rst   (sys_rst),
    .bus       (bus)
  );

  always #5 pixel_clk = ~pixel_clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always @(posedge pixel_clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- RAM on the memory port ----------------
  logic [DATA_W-1:0] ram [FRAME];

  always @(posedge pixel_clk) begin
    if (bus.mem_en && int'(bus.mem_addr) < FRAME) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  // ---------------- reference model ----------------
  // Tracks the frame image, the two pointers and how much of the current
  // burst is left; free cycles apply the grant priority rules.
  int  m_mem [FRAME];
  int  m_rd_ptr, m_wr_ptr, m_rd_left, m_wr_taken;
  bit  m_wr_open, m_pend, m_last_wr;
  acc_t  acc_q [$];
  push_t push_q[$];

  task automatic model_step();
    int  lvl, a, n;
    bit  fits, urg;
    if (sys_rst) begin
      m_rd_ptr = 0; m_wr_ptr = 0; m_rd_left = 0; m_wr_taken = 0;
      m_wr_open = 0; m_pend = 0; m_last_wr = 0;
      acc_q.delete();
      push_q.delete();
      return;
    end
    lvl = int'(bus.rd_fifo_level);
    if (m_rd_left > 0) begin
      a = m_rd_ptr;
      acc_q.push_back('{cyc, 1'b0, a, m_mem[a]});
      push_q.push_back('{cyc + 1, m_mem[a], a == FRAME - 1});
      m_rd_ptr = (a + 1) % FRAME;
      m_rd_left--;
    end else if (m_wr_open) begin
      if (!bus.wr_valid) begin
        m_wr_open = 0;
      end else begin
        a = bus.wr_sof ? 0 : m_wr_ptr;
        m_mem[a] = int'(bus.wr_data);
        acc_q.push_back('{cyc, 1'b1, a, int'(bus.wr_data)});
        m_wr_ptr = (a + 1) % FRAME;
        m_wr_taken++;
        if (m_wr_taken == BURST) m_wr_open = 0;
      end
    end else begin
      if (m_pend) begin
        m_rd_ptr = 0;
        m_pend   = 0;
      end
      fits = (lvl + BURST + 1 <= FIFO_DEPTH);
      urg  = (lvl < LOW_WM) && fits;
      n    = (FRAME - m_rd_ptr < BURST) ? FRAME - m_rd_ptr : BURST;
      if (urg) begin
        m_rd_left = n; m_last_wr = 0;
      end else if (!m_last_wr && bus.wr_valid) begin
        m_wr_open = 1; m_wr_taken = 0; m_last_wr = 1;
      end else if (fits) begin
        m_rd_left = n; m_last_wr = 0;
      end else if (bus.wr_valid) begin
        m_wr_open = 1; m_wr_taken = 0; m_last_wr = 1;
      end
    end
    if (bus.frame_start) m_pend = 1;
  endtask

  always @(posedge pixel_clk) begin
    #2;
    model_step();
  end

  // ---------------- monitor ----------------
  always @(negedge pixel_clk) begin
    if (!sys_rst) begin
      while (acc_q.size() > 0 && acc_q[0].cyc < cyc) begin
        check(1'b0, "missed_access_addr", -1, acc_q[0].addr);
        void'(acc_q.pop_front());
      end
      while (push_q.size() > 0 && push_q[0].cyc < cyc) begin
        check(1'b0, "missed_push_data", -1, push_q[0].data);
        void'(push_q.pop_front());
      end
      if (bus.mem_en) begin
        if (acc_q.size() == 0 || acc_q[0].cyc != cyc) begin
          check(1'b0, "unexpected_access_addr", int'(bus.mem_addr), -1);
        end else begin
          acc_t e;
          e = acc_q.pop_front();
          check(bus.mem_we == e.we, "access_we", int'(bus.mem_we), int'(e.we));
          check(int'(bus.mem_addr) == e.addr, "access_addr", int'(bus.mem_addr), e.addr);
          if (e.we) begin
            check(int'(bus.mem_wdata) == e.data, "write_data", int'(bus.mem_wdata), e.data);
            check(bus.wr_ready == 1'b1, "write_ready", int'(bus.wr_ready), 1);
          end
        end
      end
      if (bus.rd_fifo_wr) begin
        if (push_q.size() == 0 || push_q[0].cyc != cyc) begin
          check(1'b0, "unexpected_push_data", int'(bus.rd_fifo_wdata), -1);
        end else begin
          push_t p;
          p = push_q.pop_front();
          check(int'(bus.rd_fifo_wdata) == p.data, "push_data", int'(bus.rd_fifo_wdata), p.data);
          check(bus.rd_frame_done == p.done, "frame_done", int'(bus.rd_frame_done), int'(p.done));
        end
      end else if (bus.rd_frame_done) begin
        check(1'b0, "stray_frame_done", 1, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  int wr_addrs[$];

  task automatic step();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic set_in(input int lvl, input bit wv, input bit sof, input bit fs);
    bus.rd_fifo_level = 7'(lvl);
    bus.wr_valid      = wv;
    bus.wr_sof        = sof;
    bus.frame_start   = fs;
    bus.wr_data       = DATA_W'($urandom);
  endtask

  task automatic check_outputs_zero(input string name);
    logic any;
    any = bus.rd_fifo_wr | (|bus.rd_fifo_wdata) | bus.wr_ready | bus.mem_en |
          bus.mem_we | (|bus.mem_addr) | (|bus.mem_wdata) | bus.rd_frame_done;
    check(!any, name, int'(any), 0);
  endtask

  // Offer n beats, holding each until accepted; sof on beat index sof_idx.
  task automatic send_beats(input int n, input int sof_idx);
    int  k = 0;
    int  guard = 0;
    bit  acc;
    while (k < n && guard < n * 40 + 100) begin
      bus.wr_valid = 1'b1;
      bus.wr_sof   = (k == sof_idx);
      bus.wr_data  = DATA_W'($urandom);
      @(negedge pixel_clk);
      acc = bus.wr_ready;
      if (acc && bus.mem_en && bus.mem_we) wr_addrs.push_back(int'(bus.mem_addr));
      step();
      guard++;
      if (acc) k++;
    end
    bus.wr_valid = 1'b0;
    bus.wr_sof   = 1'b0;
    if (k < n) check(1'b0, "beat_timeout", k, n);
  endtask

  initial begin
    int guard;
    for (int i = 0; i < FRAME; i++) begin
      ram[i]   = DATA_W'($urandom);
      m_mem[i] = int'(ram[i]);
    end
    set_in(0, 0, 0, 0);
    sys_rst = 1'b1;

    // Power-up reset
    step();
    step();
    @(negedge pixel_clk);
    check_outputs_zero("reset_outputs");
    step();
    sys_rst = 1'b0;

    // Reads only: bursts 0..15, 16..31, ...
    repeat (40) begin step(); set_in(0, 0, 0, 0); end

    // Reset held three cycles in the middle of a read burst
    guard = 0;
    do begin
      @(negedge pixel_clk);
      guard++;
    end while (!(bus.mem_en && !bus.mem_we) && guard < 100);
    if (guard >= 100) check(1'b0, "wait_read_burst", 0, 1);
    step();
    sys_rst = 1'b1;
    step();
    @(negedge pixel_clk);
    check_outputs_zero("reset_hold_2");
    step();
    @(negedge pixel_clk);
    check_outputs_zero("reset_hold_3");
    step();
    sys_rst = 1'b0;
    @(negedge pixel_clk);
    check_outputs_zero("reset_release");
    @(negedge pixel_clk);
    check(bus.mem_en && !bus.mem_we, "first_grant_read", int'(bus.mem_en), 1);
    check(bus.mem_addr == '0, "first_grant_addr", int'(bus.mem_addr), 0);
    repeat (30) begin step(); set_in(0, 0, 0, 0); end

    // Alternation, urgent reads, FIFO-full boundary
    repeat (120) begin step(); set_in(20, 1, 0, 0); end
    repeat (80)  begin step(); set_in(5, 1, 0, 0); end
    repeat (80)  begin step(); set_in(48, 1, 0, 0); end
    repeat (80)  begin step(); set_in(47, 1, 0, 0); end

    // Randomized traffic
    repeat (3000) begin
      step();
      set_in($urandom_range(0, 70), $urandom_range(0, 3) != 0,
             $urandom_range(0, 40) == 0, $urandom_range(0, 150) == 0);
    end

    // Frame wrap with a frame_start landing mid-frame
    for (int i = 0; i < 450; i++) begin
      step();
      set_in(0, 0, 0, i == 60);
    end

    // Write SOF: fill to address 100, then 4 beats with SOF on the third
    step();
    set_in(48, 0, 0, 0);
    sys_rst = 1'b1;
    step();
    step();
    sys_rst = 1'b0;
    send_beats(100, -1);
    repeat (3) step();
    wr_addrs.delete();
    send_beats(4, 2);
    @(negedge pixel_clk);
    check(bus.mem_en == 1'b0, "drop_no_access", int'(bus.mem_en), 0);
    step();
    @(negedge pixel_clk);
    check(bus.wr_ready == 1'b0, "drop_ready_low", int'(bus.wr_ready), 0);
    check(wr_addrs.size() == 4, "sof_beat_count", wr_addrs.size(), 4);
    if (wr_addrs.size() == 4) begin
      check(wr_addrs[0] == 100, "sof_addr_0", wr_addrs[0], 100);
      check(wr_addrs[1] == 101, "sof_addr_1", wr_addrs[1], 101);
      check(wr_addrs[2] == 0,   "sof_addr_2", wr_addrs[2], 0);
      check(wr_addrs[3] == 1,   "sof_addr_3", wr_addrs[3], 1);
    end

    repeat (5) step();
    check(acc_q.size() == 0,  "pending_accesses", acc_q.size(), 0);
    check(push_q.size() == 0, "pending_pushes", push_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/frame_buf_arbiter.md
Name: frame_buf_arbiter

Overview:
- Shares one single-port frame buffer RAM between two requesters:
  - the display read path, which fills the pixel FIFO feeding the video timing generator's pixel_data;
  - the VIP processing write path, which stores processed pixels.
- Schedules fixed-length bursts, keeps the display FIFO fed and restarts the read pointer each frame.
- Sits between the VIP pipeline output, the display FIFO and the frame buffer RAM, all in the pixel clock domain.

Parameters:
- H_DISP, 640, active pixels per line
- V_DISP, 480, active lines per frame
- ADDR_W, 19, RAM address width; must satisfy 2^ADDR_W >= H_DISP*V_DISP
- DATA_W, 16, pixel width (RGB565)
- BURST, 16, maximum words per burst
- FIFO_DEPTH, 64, display FIFO depth in words
- LOW_WM, 16, FIFO level below which a display read is urgent

Ports:
- pixel_clk  in  1  clock
- sys_rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at the start of the vertical sync of each frame
- rd_fifo_level  in  7  current display FIFO word count
- rd_fifo_wr  out  1  display FIFO push strobe
- rd_fifo_wdata  out  DATA_W  display FIFO push data
- wr_valid  in  1  processed pixel valid
- wr_ready  out  1  processed pixel accepted when wr_valid && wr_ready
- wr_data  in  DATA_W  processed pixel
- wr_sof  in  1  qualifies a write beat as the first pixel of a frame
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable (read when 0)
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid exactly 1 cycle after a read access
- rd_frame_done  out  1  one-cycle pulse when the last pixel of a frame has been read

Behaviour:
- Clock and reset: one clock, pixel_clk; sys_rst is synchronous and active-high.
- Reset values (all to 0): every output, both address counters, the burst counter, the restart-pending flag and last_grant (= read). State goes to IDLE.
- Reset mid-burst: the burst is abandoned in the same cycle; the next cycle drives mem_en=0 and rd_fifo_wr=0.
- FSM states: IDLE, RD_BURST, WR_BURST. Every burst is followed by at least one IDLE cycle.
- Definitions: FRAME = H_DISP*V_DISP; room = (rd_fifo_level + BURST + 1 <= FIFO_DEPTH).
- IDLE, in priority order:
  - If restart-pending is set: rd_addr <= 0 and clear the flag; arbitration in the same cycle uses rd_addr = 0.
  - Urgent: rd_fifo_level < LOW_WM and room -> RD_BURST.
  - Else if last_grant == read and wr_valid -> WR_BURST.
  - Else if room -> RD_BURST.
  - Else if wr_valid -> WR_BURST.
  - Else stay in IDLE.
  - Update last_grant on each grant.
- RD_BURST:
  - Burst length = min(BURST, FRAME - rd_addr).
  - Each cycle: mem_en=1, mem_we=0, mem_addr=rd_addr, then rd_addr++.
  - One cycle after each access: rd_fifo_wr=1 and rd_fifo_wdata=mem_rdata. The last push therefore lands in the following IDLE cycle.
  - When rd_addr reaches FRAME: rd_addr wraps to 0 and rd_frame_done pulses coincident with the final push.
- WR_BURST:
  - wr_ready=1 combinationally in WR_BURST while fewer than BURST beats have been accepted.
  - On each accepted beat: mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data in the same cycle (registered outputs presented in the cycle after acceptance are not allowed).
  - wr_sof on an accepted beat forces that beat's address to 0 and sets wr_addr to 1 afterwards.
  - wr_addr wraps FRAME-1 -> 0.
  - Exit to IDLE after BURST beats, or on the first cycle with wr_valid=0 (that cycle drives mem_en=0).
- frame_start:
  - Sets restart-pending; never interrupts an active burst.
  - A frame_start coincident with the IDLE clear re-sets the flag (the set wins).
- Memory port: mem_en=0 on idle cycles, and mem_we is meaningful only when mem_en=1. Reads and writes never coincide.
- Widths: address counters are ADDR_W bits; rd_fifo_level is compared as an unsigned 7-bit value.

Test Plan:
- Reset: hold sys_rst 3 cycles mid RD_BURST -> all outputs 0 the next cycle; after release, first grant with level=0 is RD_BURST at mem_addr 0.
- Read burst: level=0, wr_valid=0 -> mem_en high 16 cycles, addresses 0..15. rd_fifo_wr then follows the same 16 cycles delayed by 1 with mem_rdata, and the next burst starts at 16.
- Alternation: level=20, wr_valid=1 continuously -> grants alternate RD 16, IDLE, WR 16, IDLE, RD.... With level=5 (urgent), read wins even when last_grant=read.
- FIFO full: level=48 -> no read grant (48+16+1 > 64); writes only. At level=47 a read is granted.
- Frame wrap: run reads until rd_addr=307200-16 -> last burst covers 307184..307199, rd_frame_done pulses once with the final push, next burst starts at 0. A frame_start during a burst takes effect only in the next IDLE.
- Write SOF: beats at wr_addr 100..103 with wr_sof on the 3rd beat -> addresses 100, 101, 0, 1. wr_valid dropping after 4 beats -> IDLE next cycle, wr_ready low.
